fifo_burst_reader: RTL and testbench

Read-side engine for the 64x8 low/high-water FIFO. It watches the FIFO's low-water flag and drains whole bursts only when a full burst is guaranteed present. It absorbs the FIFO's 1-cycle registered read latency and forwards the words on a valid/ready stream to a downstream consumer. It sits between the FIFO's read port and any back-pressuring sink (serializer, bus master).

---
 rtl/fifo_burst_reader_pkg.sv | 21 ++
 rtl/fifo_burst_reader_stream_skid_buf.sv | 51 +++++
 rtl/fifo_burst_reader.sv | 100 ++++++++++
 tb/tb_fifo_burst_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants for the 64x8 low/high-water FIFO and its burst reader.
// Also holds the reader state encoding and a pointer-width helper.
package fifo_burst_reader_pkg;

  localparam int FIFO_WIDTH     = 8;
  localparam int FIFO_DEPTH     = 6;
  localparam int FIFO_MAX_COUNT = 64;
  localparam int LOW_WATER      = FIFO_MAX_COUNT / 4;
  localparam int HIGH_WATER     = FIFO_MAX_COUNT * 3 / 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // A single-entry queue still needs a 1-bit pointer.
  function automatic int ptr_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_skid_buf.sv
// Small circular valid/ready buffer that receives FIFO read data and presents the head word.
// Storage is not reset; the head output is forced to zero whenever the buffer is empty.
module stream_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   occ
);

  localparam int PW = ptr_w(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH + 1);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (occ != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine: drains whole bursts from the low-water FIFO once a burst is guaranteed,
// absorbs the FIFO's registered read latency and forwards words on a valid/ready stream.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int BURST_LEN  = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_read_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             burst_done
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam logic [OW:0] SKID_LIM = (OW + 1)'(SKID_DEPTH);

  if (BURST_LEN > (2 ** DEPTH) / 4 || SKID_DEPTH < 2) begin : g_param_check
    $error("fifo_burst_reader: BURST_LEN must not exceed the low-water threshold and SKID_DEPTH must be >= 2");
  end

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          inflight;
  logic [OW-1:0] occ;
  logic          pop;
  logic          issue;
  logic [OW:0]   credit_use;

  assign pop        = out_valid & out_ready;
  // Words already owed to the buffer: stored, in flight, minus the one leaving this cycle.
  assign credit_use = {1'b0, occ} + (OW + 1)'(inflight) - (OW + 1)'(pop);
  assign issue      = (state == BURST) && (credit_use < SKID_LIM);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_nxt = BURST;
          cnt_nxt   = CW'(BURST_LEN);
        end
      end
      BURST: begin
        if (issue) begin
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            burst_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: read strobe issued, FIFO data returns one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      inflight <= issue;
    end
  end

  // Stage p1 -> p2: returned word captured into the output buffer.
  stream_skid_buf #(
    .WIDTH      (WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (out_data),
    .occ       (occ)
  );

  assign fifo_read_en = issue;
  assign out_valid    = (occ != '0);
  assign busy         = (state == BURST) | inflight | (occ != '0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural low-water FIFO with registered read data, a scoreboard
// queue of expected stream words, and per-window statistics on strobes and stream handshakes.
module tb_fifo_burst_reader;
  import fifo_burst_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data_out = 8'h00;
  logic       fifo_read_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       burst_done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH      (8),
    .DEPTH      (6),
    .BURST_LEN  (16),
    .SKID_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_read_en  (fifo_read_en),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .burst_done    (burst_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, low-water flag from stored count, not cleared by rst_n.
  logic [7:0] fmem [256];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       flush_req = 1'b0;
  logic       underflow = 1'b0;

  assign fifo_empty = ((wr_cnt - rd_cnt) < LOW_WATER);

  always @(posedge clk) begin
    if (flush_req) begin
      rd_cnt <= wr_cnt;
    end else if (fifo_read_en === 1'b1) begin
      if (rd_cnt == wr_cnt) underflow <= 1'b1;
      fifo_data_out <= fmem[rd_cnt[7:0]];
      rd_cnt        <= rd_cnt + 1;
    end
  end

  // Scoreboard: expected words queued at preload, compared on each stream transfer.
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra_word", {24'h0, out_data}, 32'hFFFF_FFFF);
      else                   check("sb_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic preload(input int n, input int base, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      fmem[wr_cnt[7:0]] = 8'(base + i);
      if (expect_out) exp_q.push_back(8'(base + i));
      wr_cnt++;
    end
  endtask

  int w_rd, w_xfer, w_vld, w_done, w_busy, w_first_rd, w_last_rd, w_first_v, w_last_v;
  int w_gap1, w_badgap, w_maxout;

  // Called just after a rising edge; samples each cycle on the falling edge.
  task automatic run_window(input int ncyc, input bit toggle_rdy, input int drop_en_after);
    w_rd = 0; w_xfer = 0; w_vld = 0; w_done = 0; w_busy = 0;
    w_first_rd = -1; w_last_rd = -1; w_first_v = -1; w_last_v = -1;
    w_gap1 = 0; w_badgap = 0; w_maxout = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (fifo_read_en === 1'b1) begin
        if (w_first_rd < 0)           w_first_rd = c;
        else if (c - w_last_rd == 2)  w_gap1++;
        else if (c - w_last_rd > 2)   w_badgap++;
        w_last_rd = c;
        w_rd++;
      end
      if (out_valid === 1'b1) begin
        if (w_first_v < 0) w_first_v = c;
        w_last_v = c;
        w_vld++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) w_xfer++;
      if (burst_done === 1'b1) w_done++;
      if (busy === 1'b1) w_busy++;
      if (w_rd - w_xfer > w_maxout) w_maxout = w_rd - w_xfer;
      @(posedge clk);
      #1;
      if (toggle_rdy) out_ready = (((c + 1) % 4) == 0) || (((c + 1) % 4) == 3);
      if (drop_en_after > 0 && w_rd >= drop_en_after) enable = 1'b0;
    end
  endtask

  initial begin
    int base;
    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst_read_en",    {31'h0, fifo_read_en}, 32'd0);
    check("rst_out_valid",  {31'h0, out_valid},    32'd0);
    check("rst_out_data",   {24'h0, out_data},     32'd0);
    check("rst_busy",       {31'h0, busy},         32'd0);
    check("rst_burst_done", {31'h0, burst_done},   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single burst from 20 words
    preload(16, 'h00, 1'b1);
    preload(4, 'h10, 1'b0);
    out_ready = 1'b1;
    enable    = 1'b1;
    run_window(40, 1'b0, 0);
    check("t1_reads",       w_rd, 16);
    check("t1_read_span",   w_last_rd - w_first_rd, 15);
    check("t1_valid_lat",   w_first_v - w_first_rd, 2);
    check("t1_valid_cnt",   w_vld, 16);
    check("t1_valid_span",  w_last_v - w_first_v, 15);
    check("t1_burst_done",  w_done, 1);
    check("t1_fifo_left",   wr_cnt - rd_cnt, 4);
    check("t1_sb_empty",    exp_q.size(), 0);

    // 15 words: below low water, nothing may start
    preload(11, 'h14, 1'b0);
    run_window(30, 1'b0, 0);
    check("t2_reads", w_rd, 0);
    check("t2_valid", w_vld, 0);
    check("t2_busy",  w_busy, 0);
    flush_req = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;

    // 32 words with out_ready pattern 1,0,0,1
    preload(32, 'h00, 1'b1);
    out_ready = 1'b1;
    run_window(200, 1'b1, 0);
    out_ready = 1'b1;
    check("t3_reads",       w_rd, 32);
    check("t3_xfers",       w_xfer, 32);
    check("t3_burst_done",  w_done, 2);
    check("t3_occ_le_skid", {31'h0, (w_maxout <= 2)}, 32'd1);
    check("t3_stalled",     {31'h0, (w_last_rd - w_first_rd + 1 > 32)}, 32'd1);
    check("t3_sb_empty",    exp_q.size(), 0);

    // enable dropped after 3 reads: burst completes, no second burst
    preload(32, 'h40, 1'b1);
    run_window(60, 1'b0, 3);
    check("t4_reads",      w_rd, 16);
    check("t4_read_span",  w_last_rd - w_first_rd, 15);
    check("t4_burst_done", w_done, 1);
    check("t4_fifo_left",  wr_cnt - rd_cnt, 16);

    // 48 words stored: three bursts with a single idle read cycle between
    preload(32, 'h60, 1'b1);
    enable = 1'b1;
    run_window(100, 1'b0, 0);
    check("t5_reads",      w_rd, 48);
    check("t5_gap1",       w_gap1, 2);
    check("t5_badgap",     w_badgap, 0);
    check("t5_read_span",  w_last_rd - w_first_rd, 49);
    check("t5_burst_done", w_done, 3);
    check("t5_valid_cnt",  w_vld, 48);
    check("t5_sb_empty",   exp_q.size(), 0);

    // Asynchronous reset after 5 reads
    preload(16, 'hC0, 1'b1);
    base = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rd_cnt - base >= 5) break;
    end
    check("t6_reads_before_rst", rd_cnt - base, 5);
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_read_en",   {31'h0, fifo_read_en}, 32'd0);
    check("t6_out_valid", {31'h0, out_valid},    32'd0);
    check("t6_out_data",  {24'h0, out_data},     32'd0);
    check("t6_busy",      {31'h0, busy},         32'd0);
    check("t6_done",      {31'h0, burst_done},   32'd0);
    check("t6_delivered_before_rst", exp_q.size(), 13);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t6_fifo_left", wr_cnt - rd_cnt, 11);
    rst_n     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    run_window(20, 1'b0, 0);
    check("t6_post_reads", w_rd, 0);
    check("t6_post_valid", w_vld, 0);
    check("t6_post_fifo",  wr_cnt - rd_cnt, 11);
    check("fifo_underflow", {31'h0, underflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
